// File: rtl/whac_pkg.sv
// Shared types and helpers for the whack-a-mole round sequencer.
// Holds the FSM state encoding, LFSR taps, score increments and hole-index reduction.
package whac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  // Right-shifting Fibonacci LFSR; mask selects polynomial taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int unsigned SCORE_INC_PART = 1;
  localparam int unsigned SCORE_INC_FULL = 2;

  // A 5-bit raw index is below 32 and NUM_HOLES >= 16, so one subtraction is enough.
  function automatic logic [4:0] reduce_idx(input logic [4:0] raw, input int unsigned num_holes);
    logic [4:0] idx;
    idx = raw;
    if (32'(raw) >= num_holes) begin
      idx = raw - 5'(num_holes);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mole_pattern_gen.sv
// Free-running LFSR that turns its current value into a one- or two-mole hole mask.
// The mask is always nonzero because the first index is always set.
module mole_pattern_gen
  import whac_pkg::*;
#(
  parameter int          NUM_HOLES = 18,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 two_mole,
  output logic [NUM_HOLES-1:0] pattern
);

  localparam logic [NUM_HOLES-1:0] ONE = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [4:0]  idx_a;
  logic [4:0]  idx_b;

  assign lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign idx_a = reduce_idx(lfsr_q[4:0], NUM_HOLES);
  assign idx_b = reduce_idx(lfsr_q[12:8], NUM_HOLES);

  always_comb begin
    pattern = ONE << idx_a;
    if (two_mole) begin
      pattern = pattern | (ONE << idx_b);
    end
  end

endmodule

// File: rtl/mole_round_controller.sv
// Whack-a-mole game sequencer: alternates all-down gaps with timed mole-up windows,
// keeps score, lives and level from the hit-detection pulses, and ends the game at zero lives.
module mole_round_controller
  import whac_pkg::*;
#(
  parameter int          NUM_HOLES      = 18,
  parameter int          GAP_TICKS      = 500,
  parameter int          UP_TICKS_INIT  = 1500,
  parameter int          UP_TICKS_MIN   = 300,
  parameter int          UP_TICKS_STEP  = 100,
  parameter int          TWO_MOLE_LEVEL = 4,
  parameter int          LIVES          = 3,
  parameter int          SCORE_W        = 10,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 miss,
  input  logic                 non_full_clear_hit,
  input  logic                 full_clear_hit,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic                 game_in_progress,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           lives,
  output logic [3:0]           level,
  output logic                 game_over
);

  localparam int MAX_T = (GAP_TICKS > UP_TICKS_INIT) ? GAP_TICKS : UP_TICKS_INIT;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  // The window is held as its last tick index so it fits the counter width.
  localparam logic [CW-1:0]      GAP_LAST   = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0]      WIN_INIT   = CW'(UP_TICKS_INIT - 1);
  localparam logic [CW-1:0]      WIN_FLOOR  = CW'(UP_TICKS_MIN - 1);
  localparam logic [CW-1:0]      WIN_STEP   = CW'(UP_TICKS_STEP);
  localparam logic [31:0]        SHRINK_MIN = 32'(UP_TICKS_MIN - 1 + UP_TICKS_STEP);
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
  localparam logic [4:0]         TWO_LVL    = 5'(TWO_MOLE_LEVEL);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_e               state_q, state_d;
  logic [CW-1:0]        counter_q, counter_d;
  logic [CW-1:0]        win_q, win_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic [3:0]           level_q, level_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;

  logic                 in_game;
  logic                 two_mole;
  logic [NUM_HOLES-1:0] pattern;
  logic [1:0]           score_inc;
  logic [SCORE_W:0]     score_sum;
  logic [CW-1:0]        win_shrunk;

  mole_pattern_gen #(
    .NUM_HOLES (NUM_HOLES),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern (
    .clk      (clk),
    .rst_n    (rst_n),
    .two_mole (two_mole),
    .pattern  (pattern)
  );

  assign in_game  = (state_q == ST_GAP) || (state_q == ST_UP);
  assign two_mole = {1'b0, level_q} >= TWO_LVL;

  assign score_inc = (non_full_clear_hit ? 2'(SCORE_INC_PART) : 2'd0)
                   + (full_clear_hit     ? 2'(SCORE_INC_FULL) : 2'd0);
  assign score_sum = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, score_inc};

  assign win_shrunk = (32'(win_q) >= SHRINK_MIN) ? (win_q - WIN_STEP) : WIN_FLOOR;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    win_d     = win_q;
    score_d   = score_q;
    lives_d   = lives_q;
    level_d   = level_q;
    mole_d    = mole_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        mole_d = '0;
        if (start) begin
          state_d   = ST_GAP;
          counter_d = '0;
          win_d     = WIN_INIT;
          score_d   = '0;
          lives_d   = LIVES_INIT;
          level_d   = 4'd0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (counter_q == GAP_LAST) begin
            mole_d    = pattern;
            counter_d = '0;
            state_d   = ST_UP;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end
      ST_UP: begin
        // A full clear wins over a coincident timeout and is the only exit that levels up.
        if (full_clear_hit) begin
          mole_d    = '0;
          counter_d = '0;
          state_d   = ST_GAP;
          level_d   = (level_q == 4'hF) ? level_q : level_q + 4'd1;
          win_d     = win_shrunk;
        end else if (tick) begin
          if (counter_q == win_q) begin
            mole_d    = '0;
            counter_d = '0;
            state_d   = ST_GAP;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        mole_d  = '0;
      end
    endcase

    if (in_game) begin
      score_d = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
      if (miss && (lives_q != 2'd0)) begin
        lives_d = lives_q - 2'd1;
        if (lives_q == 2'd1) begin
          state_d   = ST_OVER;
          mole_d    = '0;
          counter_d = '0;
          level_d   = level_q;
          win_d     = win_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      win_q     <= WIN_INIT;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      level_q   <= 4'd0;
      mole_q    <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      win_q     <= win_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      mole_q    <= mole_d;
    end
  end

  assign mole_positions   = mole_q;
  assign game_in_progress = in_game;
  assign score            = score_q;
  assign lives            = lives_q;
  assign level            = level_q;
  assign game_over        = (state_q == ST_OVER);

endmodule

// File: tb/tb_mole_round_controller.sv
// Bench for mole_round_controller: vector table, directed multi-cycle sequences and
// randomized traffic, all compared every cycle against a behavioural game model.
module tb_mole_round_controller;

  localparam int NH      = 18;
  localparam int GAP_T   = 2;
  localparam int UP_INIT = 4;
  localparam int UP_MIN  = 2;
  localparam int UP_STEP = 1;
  localparam int TWO_LVL = 4;
  localparam int LIVES_N = 3;
  localparam int SW      = 6;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int SMAX    = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, tick, start, miss, nfc, fc;
  logic [NH-1:0] mole_positions;
  logic          game_in_progress, game_over;
  logic [SW-1:0] score;
  logic [1:0]    lives;
  logic [3:0]    level;

  int n_checks = 0;
  int n_err    = 0;

  mole_round_controller #(
    .NUM_HOLES(NH), .GAP_TICKS(GAP_T), .UP_TICKS_INIT(UP_INIT), .UP_TICKS_MIN(UP_MIN),
    .UP_TICKS_STEP(UP_STEP), .TWO_MOLE_LEVEL(TWO_LVL), .LIVES(LIVES_N), .SCORE_W(SW),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .miss(miss),
    .non_full_clear_hit(nfc), .full_clear_hit(fc),
    .mole_positions(mole_positions), .game_in_progress(game_in_progress),
    .score(score), .lives(lives), .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Behavioural model of the game
  typedef enum int {P_IDLE, P_GAP, P_UP, P_OVER} phase_t;
  phase_t        m_phase;
  int            m_elapsed, m_window, m_score, m_lives, m_level;
  logic [NH-1:0] m_moles;
  logic [15:0]   m_lfsr;

  function automatic logic [NH-1:0] model_pattern(input logic [15:0] l, input int lvl);
    logic [NH-1:0] p;
    int a, b;
    a = int'(l & 16'h001F) % NH;
    b = int'((l >> 8) & 16'h001F) % NH;
    p = '0;
    p[a] = 1'b1;
    if (lvl >= TWO_LVL) p[b] = 1'b1;
    return p;
  endfunction

  task automatic model_step(input bit rs, input bit st, input bit tk, input bit ms,
                            input bit nf, input bit fh);
    logic [NH-1:0] pat;
    if (!rs) begin
      m_phase = P_IDLE; m_moles = '0; m_score = 0; m_lives = LIVES_N; m_level = 0;
      m_window = UP_INIT; m_elapsed = 0; m_lfsr = SEED;
      return;
    end
    pat    = model_pattern(m_lfsr, m_level);
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    if (m_phase == P_IDLE || m_phase == P_OVER) begin
      m_moles = '0;
      if (st) begin
        m_phase = P_GAP; m_score = 0; m_lives = LIVES_N; m_level = 0;
        m_window = UP_INIT; m_elapsed = 0;
      end
      return;
    end
    m_score = m_score + (nf ? 1 : 0) + (fh ? 2 : 0);
    if (m_score > SMAX) m_score = SMAX;
    if (ms) begin
      m_lives = m_lives - 1;
      if (m_lives == 0) begin
        m_phase = P_OVER; m_moles = '0; m_elapsed = 0;
        return;
      end
    end
    if (m_phase == P_GAP) begin
      if (tk) begin
        m_elapsed++;
        if (m_elapsed == GAP_T) begin
          m_phase = P_UP; m_moles = pat; m_elapsed = 0;
        end
      end
    end else if (fh) begin
      m_phase = P_GAP; m_moles = '0; m_elapsed = 0;
      if (m_level < 15) m_level++;
      m_window = (m_window - UP_STEP < UP_MIN) ? UP_MIN : m_window - UP_STEP;
    end else if (tk) begin
      m_elapsed++;
      if (m_elapsed == m_window) begin
        m_phase = P_GAP; m_moles = '0; m_elapsed = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  task automatic compare_model();
    check("mdl_mole", mole_positions, m_moles);
    check("mdl_gip", game_in_progress, (m_phase == P_GAP || m_phase == P_UP));
    check("mdl_score", score, m_score);
    check("mdl_lives", lives, m_lives);
    check("mdl_level", level, m_level);
    check("mdl_over", game_over, (m_phase == P_OVER));
  endtask

  // Drive one cycle's inputs, let the edge happen, advance the model, compare after the edge.
  task automatic cycle(input bit rs, input bit st, input bit tk, input bit ms,
                       input bit nf, input bit fh);
    rst_n = rs; start = st; tick = tk; miss = ms; nfc = nf; fc = fh;
    @(posedge clk);
    model_step(rs, st, tk, ms, nf, fh);
    #1;
    compare_model();
  endtask

  task automatic idle_cycle();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_mole(input bit want_up, input int budget, input string name);
    int n;
    n = 0;
    while (((|mole_positions) !== want_up) && n < budget) begin
      idle_cycle();
      n++;
    end
    if ((|mole_positions) !== want_up) expire(name);
  endtask

  typedef struct {
    bit st, ms, nf, fh;
    bit up, gip, over;
    int sc, lv, lvl;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit ms, input bit nf, input bit fh,
                              input bit up, input bit gip, input int sc, input int lv,
                              input int lvl, input bit over);
    vec_t v;
    v.st = st; v.ms = ms; v.nf = nf; v.fh = fh;
    v.up = up; v.gip = gip; v.sc = sc; v.lv = lv; v.lvl = lvl; v.over = over;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    int pc, lim, n;
    //            st ms nf fh   up gip sc lv lvl over
    tbl[0]  = mk(1, 0, 0, 0,   0, 1,  0, 3, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,   0, 1,  0, 3, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,   1, 1,  0, 3, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,   1, 1,  0, 3, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0,   1, 1,  0, 3, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,   1, 1,  0, 3, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,   0, 1,  0, 3, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,   0, 1,  0, 3, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,   1, 1,  0, 3, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0,   1, 1,  0, 3, 0, 0);
    tbl[10] = mk(0, 0, 0, 1,   0, 1,  2, 3, 1, 0);
    tbl[11] = mk(0, 0, 0, 0,   0, 1,  2, 3, 1, 0);
    tbl[12] = mk(0, 0, 0, 0,   1, 1,  2, 3, 1, 0);
    tbl[13] = mk(0, 0, 0, 0,   1, 1,  2, 3, 1, 0);
    tbl[14] = mk(0, 0, 0, 0,   1, 1,  2, 3, 1, 0);
    tbl[15] = mk(0, 0, 0, 0,   0, 1,  2, 3, 1, 0);
    tbl[16] = mk(0, 0, 1, 0,   0, 1,  3, 3, 1, 0);
    tbl[17] = mk(0, 0, 1, 0,   1, 1,  4, 3, 1, 0);
    tbl[18] = mk(0, 1, 1, 0,   1, 1,  5, 2, 1, 0);
    tbl[19] = mk(0, 1, 1, 0,   1, 1,  6, 1, 1, 0);
    tbl[20] = mk(0, 0, 0, 0,   0, 1,  6, 1, 1, 0);
    tbl[21] = mk(1, 0, 0, 0,   0, 1,  6, 1, 1, 0);
    tbl[22] = mk(0, 0, 0, 0,   1, 1,  6, 1, 1, 0);
    tbl[23] = mk(1, 0, 0, 0,   1, 1,  6, 1, 1, 0);
    tbl[24] = mk(0, 1, 0, 0,   0, 0,  6, 0, 1, 1);
    tbl[25] = mk(0, 0, 1, 1,   0, 0,  6, 0, 1, 1);
    tbl[26] = mk(0, 1, 0, 0,   0, 0,  6, 0, 1, 1);
    tbl[27] = mk(1, 0, 0, 0,   0, 1,  0, 3, 0, 0);

    // Reset state
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_mole", mole_positions, 0);
    check("rst_gip", game_in_progress, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, LIVES_N);
    check("rst_level", level, 0);
    check("rst_over", game_over, 0);

    // Round timing, full clear, simultaneous hit+miss, ignored start/hits
    for (int i = 0; i < 28; i++) begin
      cycle(1'b1, tbl[i].st, 1'b1, tbl[i].ms, tbl[i].nf, tbl[i].fh);
      check($sformatf("tbl%0d_up", i), |mole_positions, tbl[i].up);
      check($sformatf("tbl%0d_gip", i), game_in_progress, tbl[i].gip);
      check($sformatf("tbl%0d_score", i), score, tbl[i].sc);
      check($sformatf("tbl%0d_lives", i), lives, tbl[i].lv);
      check($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      check($sformatf("tbl%0d_over", i), game_over, tbl[i].over);
    end

    // Three timed-out rounds, each followed by a late miss
    for (int r = 0; r < 3; r++) begin
      wait_mole(1'b1, 20, "t3_rise");
      wait_mole(1'b0, 20, "t3_fall");
      idle_cycle();
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t3_lives", lives, LIVES_N - 1 - r);
    end
    check("t3_over", game_over, 1);
    check("t3_gip", game_in_progress, 0);
    check("t3_mole", mole_positions, 0);
    check("t3_score", score, 0);

    // Reset in the middle of an up window
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_mole(1'b1, 20, "t6_rise");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t6_start_ignored", score, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_mole", mole_positions, 0);
    check("t6_gip", game_in_progress, 0);
    check("t6_score", score, 0);
    check("t6_lives", lives, LIVES_N);
    check("t6_level", level, 0);
    check("t6_over", game_over, 0);
    idle_cycle();
    check("t6_stays_idle", game_in_progress, 0);

    // Level up to two-mole patterns and the window floor
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 10; r++) begin
      wait_mole(1'b1, 20, "t5_rise");
      pc  = $countones(mole_positions);
      lim = (m_level >= TWO_LVL) ? 2 : 1;
      check("t5_popcount_ok", (pc >= 1 && pc <= lim), 1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    check("t5_level", level, 10);
    check("t5_score", score, 20);
    wait_mole(1'b1, 20, "t5_last_rise");
    n = 0;
    while ((|mole_positions) && n < 20) begin
      idle_cycle();
      n++;
    end
    check("t5_floor_window", n, UP_MIN);

    // Randomized traffic against the model
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 499) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
